// File: rtl/vx_bits_insert_buf.sv
// Inserts an S-bit field into an N-bit payload at bit POS behind a registered skid buffer.
// Optional macro VX_BITS_INSERT_SEQ_EN: the field comes from an internal accept-sequence counter.
module vx_bits_insert_buf #(
  parameter int N   = 8,
  parameter int S   = 1,
  parameter int POS = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [N-1:0]     data_in,
  input  logic [S-1:0]     bits_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [N+S-1:0]   data_out
);

  localparam int W = N + S;

  generate
    if (N < 1 || S < 1 || POS < 0 || POS > N) begin : g_bad_param
      $error("vx_bits_insert_buf: illegal parameters N=%0d S=%0d POS=%0d", N, S, POS);
    end
  endgenerate

  // Bits below POS stay put, bits at or above POS move up by S, the field fills the gap.
  function automatic logic [W-1:0] insert_field(input logic [N-1:0] d, input logic [S-1:0] f);
    logic [W-1:0] ext_d;
    logic [W-1:0] ext_f;
    logic [W-1:0] lo_mask;
    ext_d   = {{S{1'b0}}, d};
    ext_f   = {{N{1'b0}}, f};
    lo_mask = (W'(1'b1) << POS) - W'(1'b1);
    return (ext_d & lo_mask) | ((ext_d & ~lo_mask) << S) | (ext_f << POS);
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;
  logic           main_valid_q;
  logic           skid_valid_q;

  logic           accept_s;
  logic           emit_s;
  logic [S-1:0]   field_s;
  logic [W-1:0]   ins_s;

`ifdef VX_BITS_INSERT_SEQ_EN
  logic [S-1:0]   seq_q;
  logic           unused_bits_s;

  assign unused_bits_s = ^bits_in;

  // Sequence counter: current value tags the accepted beat, then advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q <= {S{1'b0}};
    end else if (accept_s) begin
      seq_q <= seq_q + S'(1'b1);
    end else begin
      seq_q <= seq_q;
    end
  end
`endif

  // Handshake qualification and the widened beat to be stored on accept.
  always_comb begin
    accept_s = valid_in && !skid_valid_q;
    emit_s   = main_valid_q && ready_out;
`ifdef VX_BITS_INSERT_SEQ_EN
    field_s  = seq_q;
`else
    field_s  = bits_in;
`endif
    ins_s    = insert_field(data_in, field_s);
  end

  // Elastic stage FSM; main register feeds the outputs, skid catches the beat accepted under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      main_q       <= {W{1'b0}};
      skid_q       <= {W{1'b0}};
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_q       <= ins_s;
            main_valid_q <= 1'b1;
            state_q      <= ST_ONE;
          end else begin
            state_q      <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            main_q       <= ins_s;
            state_q      <= ST_ONE;
          end else if (accept_s) begin
            skid_q       <= ins_s;
            skid_valid_q <= 1'b1;
            state_q      <= ST_TWO;
          end else if (emit_s) begin
            main_valid_q <= 1'b0;
            state_q      <= ST_EMPTY;
          end else begin
            state_q      <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (emit_s) begin
            main_q       <= skid_q;
            skid_valid_q <= 1'b0;
            state_q      <= ST_ONE;
          end else begin
            state_q      <= ST_TWO;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean empty buffer.
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          state_q      <= ST_EMPTY;
        end
      endcase
    end
  end

  assign ready_in  = !skid_valid_q;
  assign valid_out = main_valid_q;
  assign data_out  = main_q;

endmodule

// File: tb/tb_vx_bits_insert_buf.sv
// Scoreboard bench for vx_bits_insert_buf: three instances (POS=0,3,8) share one stimulus stream.
// Honours VX_BITS_INSERT_SEQ_EN when the bundle is built with it.
module tb_vx_bits_insert_buf;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_in;
  logic [1:0] bits_in;

  logic       ready0, ready3, ready8;
  logic       vo0, vo3, vo8;
  logic [9:0] do0, do3, do8;

  int tests = 0;
  int fails = 0;

  logic [9:0] q0[$];
  logic [9:0] q3[$];
  logic [9:0] q8[$];
  logic [1:0] seq_m = 2'd0;

  always #5 clk = ~clk;

  vx_bits_insert_buf #(.N(8), .S(2), .POS(0)) u_pos0 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready0),
    .data_in(data_in), .bits_in(bits_in), .valid_out(vo0), .ready_out(ready_out), .data_out(do0));
  vx_bits_insert_buf #(.N(8), .S(2), .POS(3)) u_pos3 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready3),
    .data_in(data_in), .bits_in(bits_in), .valid_out(vo3), .ready_out(ready_out), .data_out(do3));
  vx_bits_insert_buf #(.N(8), .S(2), .POS(8)) u_pos8 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready8),
    .data_in(data_in), .bits_in(bits_in), .valid_out(vo8), .ready_out(ready_out), .data_out(do8));

  // Reference: upper payload bits shift up by the field width, field lands at pos.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] f, input int pos);
    int unsigned dv;
    int unsigned hi;
    int unsigned lo;
    dv = d;
    hi = (dv >> pos) << (pos + 2);
    lo = dv % (32'd1 << pos);
    return 10'(hi + (int'(f) << pos) + lo);
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop on every emitted beat, push model result on every accepted beat.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [1:0] f;
    if (!reset_n) begin
      q0.delete(); q3.delete(); q8.delete();
      seq_m = 2'd0;
    end else begin
      if (vo0 && ready_out) begin
        if (q0.size() == 0) begin tests++; fails++; $display("FAIL out_pos0: unexpected beat %0h", do0); end
        else begin e = q0.pop_front(); check("out_pos0", do0, e); end
      end
      if (vo3 && ready_out) begin
        if (q3.size() == 0) begin tests++; fails++; $display("FAIL out_pos3: unexpected beat %0h", do3); end
        else begin e = q3.pop_front(); check("out_pos3", do3, e); end
      end
      if (vo8 && ready_out) begin
        if (q8.size() == 0) begin tests++; fails++; $display("FAIL out_pos8: unexpected beat %0h", do8); end
        else begin e = q8.pop_front(); check("out_pos8", do8, e); end
      end
      if (valid_in && ready3) begin
`ifdef VX_BITS_INSERT_SEQ_EN
        f = seq_m;
        seq_m = seq_m + 2'd1;
`else
        f = bits_in;
`endif
        q0.push_back(model(data_in, f, 0));
        q3.push_back(model(data_in, f, 3));
        q8.push_back(model(data_in, f, 8));
      end
    end
  end

  initial begin
    bit acc;
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = 8'h00;
    bits_in   = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid_out", {9'd0, vo3}, 10'd0);
    check("rst_ready_in", {9'd0, ready3}, 10'd1);
    check("rst_data_out", do3, 10'd0);

`ifdef VX_BITS_INSERT_SEQ_EN
    // Counter-sourced field: 0,1,2,3,0 regardless of bits_in.
    @(posedge clk); #1;
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bits_in = 2'($urandom);
      @(negedge clk);
      check("seq_field", do0, 10'(i % 4));
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
`else
    // Directed insertion vector at all three positions.
    @(posedge clk); #1;
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 8'hA5;
    bits_in   = 2'b11;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("vec_valid", {9'd0, vo3}, 10'd1);
    check("vec_pos3", do3, 10'h29D);
    check("vec_pos0", do0, 10'h297);
    check("vec_pos8", do8, 10'h3A5);
`endif
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A1 to main, A2 to skid, A3 stalls.
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 8'hA1;
    bits_in   = 2'b01;
    @(posedge clk); #1;
    data_in = 8'hA2;
    bits_in = 2'b10;
    @(posedge clk); #1;
    data_in = 8'hA3;
    bits_in = 2'b11;
    @(negedge clk);
    check("bp_stall", {9'd0, ready3}, 10'd0);
    @(posedge clk); #1;
    check("bp_hold_valid", {9'd0, vo3}, 10'd1);
    check("bp_hold_data", do3, model(8'hA1, 2'b01, 3));
    ready_out = 1'b1;
    @(negedge clk);
    check("bp_still_full", {9'd0, ready3}, 10'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_back", {9'd0, ready3}, 10'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Streaming: 16 back-to-back beats.
    ready_out = 1'b1;
    valid_in  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'($urandom);
      bits_in = 2'($urandom);
      @(negedge clk);
      check("stream_ready", {9'd0, ready3}, 10'd1);
      if (i > 0) check("stream_valid", {9'd0, vo3}, 10'd1);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    @(negedge clk);
    check("stream_last", {9'd0, vo3}, 10'd1);
    repeat (3) @(posedge clk);
    #1;

    // Reset while holding two beats.
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 8'h3C;
    @(posedge clk); #1;
    data_in = 8'hC3;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("two_full", {9'd0, ready3}, 10'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2;
    check("async_rst_valid", {9'd0, vo3}, 10'd0);
    check("async_rst_ready", {9'd0, ready3}, 10'd1);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_beat", {9'd0, vo3}, 10'd0);
      check("post_rst_ready", {9'd0, ready3}, 10'd1);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure; source holds a beat until taken.
    valid_in = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      acc = valid_in && ready3;
      @(posedge clk); #1;
      if (!valid_in || acc) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = 8'($urandom);
        bits_in  = 2'($urandom);
      end
      ready_out = ($urandom_range(0, 2) != 0);
    end

    // Drain everything and confirm nothing extra appears.
    @(negedge clk);
    acc = valid_in && ready3;
    @(posedge clk); #1;
    if (!acc) begin
      for (int c = 0; c < 8 && valid_in; c++) begin
        ready_out = 1'b1;
        @(negedge clk);
        acc = valid_in && ready3;
        @(posedge clk); #1;
        if (acc) valid_in = 1'b0;
      end
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q3.size() == 0 && q8.size() == 0) break;
    end
    tests++;
    if (q0.size() != 0 || q3.size() != 0 || q8.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d beats outstanding expected 0", q3.size() + q0.size() + q8.size());
    end
    repeat (2) begin
      @(negedge clk);
      check("idle_no_beat", {9'd0, vo3}, 10'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
